program_sequencer_cached: RTL and testbench
===========================================

Name: program_sequencer_cached

Overview:
Parametrised next-generation program sequencer with a direct-mapped instruction-cache controller. It produces the next program-memory address and holds the PC on a cache miss. On a miss it runs a line-fill state machine that streams a whole line from program ROM into the external cache RAM, tolerating configurable ROM read latency. Sits between the core's branch logic and the cache RAM/ROM pair; unlike the previous sequencer, it tracks valid bits per line and supports flush.

Parameters:
ADDR_W, 8, program address width
LINES, 4, cache lines (power of 2, >=2); IDX_W = log2(LINES)
WORDS, 8, words per line (power of 2, >=2); OFF_W = log2(WORDS)
ROM_LAT, 1, ROM read latency in cycles (1..3)
Derived: TAG_W = ADDR_W - IDX_W - OFF_W, which must be >=1.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous program restart
jmp, jmp_nz, dont_jmp  in  1 each  branch controls, same semantics as the current sequencer
jmp_addr  in  ADDR_W-4  jump target; target = {jmp_addr, 4'h0}
flush  in  1  invalidate the whole cache
pm_addr  out  ADDR_W  next PC (combinational)
pc  out  ADDR_W  program counter (registered)
hold_out  out  1  instruction not available, core stalls
rom_address  out  ADDR_W  ROM fill address
cache_wren  out  1  cache RAM write enable
cache_wrline  out  IDX_W  write line
cache_wroffset  out  OFF_W  write word
cache_rdline  out  IDX_W  = pm_addr index field
cache_rdoffset  out  OFF_W  = pm_addr[OFF_W-1:0]

Behaviour:
- Address fields: off = [OFF_W-1:0], idx = [OFF_W+IDX_W-1:OFF_W], tag = [ADDR_W-1:OFF_W+IDX_W].
- pm_addr priority:
  1. sync_reset gives 0.
  2. state != RUN gives pc.
  3. jmp | (jmp_nz & ~dont_jmp) gives {jmp_addr, 4'h0}.
  4. Otherwise pc+1, wrapping modulo 2^ADDR_W.
- pc <= pm_addr every cycle.
- miss = (state==RUN) & (~valid[idx(pm_addr)] | tag_mem[idx(pm_addr)] != tag(pm_addr)).
- hold_out = miss | (state != RUN).
- FSM:
  - RUN: on miss, latch fill_line/fill_tag from pm_addr, clear the issue counter, and go to FILL.
  - FILL: issue rom_address = {fill_tag, fill_line, issue_cnt} for issue_cnt 0..WORDS-1, one per cycle.
  - Write pipeline: a ROM_LAT-deep shift of (valid, offset) drives cache_wren/cache_wroffset; cache_wrline = fill_line.
  - On the cycle of the last write (offset WORDS-1): set valid[fill_line]=1, set tag_mem[fill_line]=fill_tag, and go to RUN.
- FILL lasts WORDS+ROM_LAT cycles. Total hold_out per miss = WORDS+ROM_LAT+1 cycles.
- Only the filled line's valid bit is set. Other lines are untouched, and a conflicting line is evicted by tag overwrite.
- Branch inputs are ignored while state != RUN.
- rom_address is 0 in RUN. cache_wren is 0 except during pipeline writes.
- Invalidate event = flush | (sync_reset & ~sync_reset_q), the one-shot rising edge. Its effects:
  - clear all valid bits;
  - abort any fill by emptying the pipeline and forcing cache_wren low the same cycle;
  - return to RUN.
  - A miss is then re-detected on the next RUN evaluation.
  - The invalidate event has priority over fill completion.
- sync_reset held high keeps pm_addr = 0 and repeatedly re-fills line 0 after the first invalidate.
- reset_n low (asynchronous) sets:
  - pc=0, state=RUN;
  - valid=0, tag_mem=0;
  - write pipeline empty, sync_reset_q=0;
  - stats counters 0.
- Reset release occurs mid-operation with no pending fill.

Optional Feature:
Macro ICACHE_STATS_EN.
- When defined, three extra outputs are added: hit_count[15:0], miss_count[15:0], stall_count[15:0].
- Per cycle in RUN with not sync_reset: hit_count increments if ~miss, and miss_count increments on a miss.
- stall_count increments every cycle hold_out=1.
- All counters saturate at 16'hFFFF and clear on reset_n or an invalidate event.
- When undefined, these ports and their logic are absent.

Test Plan:
1. Defaults; release reset_n; pulse sync_reset for 1 cycle.
   Required: miss at 0x00; rom_address 0x00..0x07 on consecutive cycles; cache_wren with offsets 0..7 lagging by 1 cycle; hold_out high 10 cycles; then pc runs 0x01, 0x02, ...
2. Sequential run from 0x00.
   Required: no hold through 0x07; miss at 0x08 fills line 1 (rom_address 0x08..0x0F); line 0 stays valid. Returning via jmp_addr=4'h0 hits with hold_out=0.
3. With line 0 holding tag 0, jmp with jmp_addr=4'h2 (0x20).
   Required: conflict miss; rom_address 0x20..0x27; tag_mem[0]=1. A later jump to 0x00 misses again.
4. ROM_LAT=3.
   Required: writes lag issues by 3 cycles; hold_out high 12 cycles; the last write carries offset 7.
5. Assert flush at the 4th FILL cycle.
   Required: cache_wren drops the same cycle; all valid bits clear; a refill of the same line restarts from offset 0.
6. ICACHE_STATS_EN with scenario 2.
   Required: after 16 instructions, miss_count=2, stall_count=20, and hit_count equals RUN cycles minus 2; pulsing flush zeroes all counters.

Source files
------------

// File: rtl/program_sequencer_cached_if.sv
// Cache-RAM / program-ROM side of program_sequencer_cached: fill address, write port and read index.
interface program_sequencer_cached_if #(
    parameter int ADDR_W = 8,
    parameter int LINES  = 4,
    parameter int WORDS  = 8
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS);

    logic [ADDR_W-1:0] rom_address;
    logic              cache_wren;
    logic [IDX_W-1:0]  cache_wrline;
    logic [OFF_W-1:0]  cache_wroffset;
    logic [IDX_W-1:0]  cache_rdline;
    logic [OFF_W-1:0]  cache_rdoffset;

    modport master (
        output rom_address, cache_wren, cache_wrline, cache_wroffset,
        output cache_rdline, cache_rdoffset
    );

    modport slave (
        input rom_address, cache_wren, cache_wrline, cache_wroffset,
        input cache_rdline, cache_rdoffset
    );
endinterface

// File: rtl/program_sequencer_cached.sv
// Next-PC sequencer with a direct-mapped instruction-cache line-fill controller.
// Defining ICACHE_STATS_EN adds saturating hit/miss/stall counters.
module program_sequencer_cached #(
    parameter int ADDR_W  = 8,
    parameter int LINES   = 4,
    parameter int WORDS   = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sync_reset,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jmp,
    input  logic [ADDR_W-5:0] jmp_addr,
    input  logic              flush,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              hold_out,
`ifdef ICACHE_STATS_EN
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
    output logic [15:0]       stall_count,
`endif
    program_sequencer_cached_if.master mem
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic {RUN, FILL} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q;
    logic               sync_reset_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_mem_q [LINES];
    logic [IDX_W-1:0]   fill_line_q;
    logic [TAG_W-1:0]   fill_tag_q;
    logic [OFF_W:0]     issue_cnt_q;
    logic [ROM_LAT-1:0] pipe_vld_q;
    logic [OFF_W-1:0]   pipe_off_q [ROM_LAT];

    logic              jump_taken, invalidate, miss, issuing;
    logic              wr_vld, last_write, start_fill;
    logic [IDX_W-1:0]  pm_idx;
    logic [TAG_W-1:0]  pm_tag;

    assign jump_taken = jmp | (jmp_nz & ~dont_jmp);
    assign invalidate = flush | (sync_reset & ~sync_reset_q);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pm_addr = pc_q + ADDR_W'(1);
        if (sync_reset)
            pm_addr = '0;
        else if (state_q != RUN)
            pm_addr = pc_q;
        else if (jump_taken)
            pm_addr = {jmp_addr, 4'h0};
    end

    assign pm_idx   = pm_addr[OFF_W+IDX_W-1:OFF_W];
    assign pm_tag   = pm_addr[ADDR_W-1:OFF_W+IDX_W];
    assign miss     = (state_q == RUN) && (!valid_q[pm_idx] || tag_mem_q[pm_idx] != pm_tag);
    assign hold_out = miss || (state_q != RUN);
    assign pc       = pc_q;

    assign issuing    = (state_q == FILL) && (issue_cnt_q < (OFF_W+1)'(WORDS));
    assign wr_vld     = pipe_vld_q[ROM_LAT-1];
    assign last_write = wr_vld && (pipe_off_q[ROM_LAT-1] == OFF_W'(WORDS - 1));

    // An invalidate in the same cycle as a write kills that write on the RAM port.
    assign mem.cache_wren     = wr_vld && !invalidate;
    assign mem.cache_wroffset = pipe_off_q[ROM_LAT-1];
    assign mem.cache_wrline   = fill_line_q;
    assign mem.cache_rdline   = pm_idx;
    assign mem.cache_rdoffset = pm_addr[OFF_W-1:0];
    assign mem.rom_address    = issuing ? {fill_tag_q, fill_line_q, issue_cnt_q[OFF_W-1:0]} : '0;

    always_comb begin
        state_d    = state_q;
        start_fill = 1'b0;
        case (state_q)
            RUN:  if (miss) begin
                      state_d    = FILL;
                      start_fill = 1'b1;
                  end
            FILL: if (last_write) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (invalidate) begin
            state_d    = RUN;
            start_fill = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            pc_q         <= '0;
            sync_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pm_addr;
            sync_reset_q <= sync_reset;
        end
    end

    // NOTE: the tag/valid arrays are tiny flop arrays, so they take the reset; a RAM would not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) tag_mem_q[i] <= '0;
        end else if (invalidate) begin
            valid_q <= '0;
        end else if (state_q == FILL && last_write) begin
            valid_q[fill_line_q]   <= 1'b1;
            tag_mem_q[fill_line_q] <= fill_tag_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_line_q <= '0;
            fill_tag_q  <= '0;
            issue_cnt_q <= '0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < ROM_LAT; i++) pipe_off_q[i] <= '0;
        end else begin
            if (start_fill) begin
                fill_line_q <= pm_idx;
                fill_tag_q  <= pm_tag;
                issue_cnt_q <= '0;
            end else if (issuing) begin
                issue_cnt_q <= issue_cnt_q + (OFF_W+1)'(1);
            end
            // The shift models ROM read latency: each issued offset emerges ROM_LAT cycles later.
            if (invalidate) begin
                pipe_vld_q <= '0;
            end else begin
                pipe_vld_q[0] <= issuing;
                pipe_off_q[0] <= issue_cnt_q[OFF_W-1:0];
                for (int i = 1; i < ROM_LAT; i++) begin
                    pipe_vld_q[i] <= pipe_vld_q[i-1];
                    pipe_off_q[i] <= pipe_off_q[i-1];
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic run_active;
    assign run_active = (state_q == RUN) && !sync_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            stall_count <= '0;
        end else if (invalidate) begin
            hit_count   <= '0;
            miss_count  <= '0;
            stall_count <= '0;
        end else begin
            if (run_active && !miss && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (run_active && miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            if (hold_out && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_program_sequencer_cached.sv
// Directed, table-driven bench for program_sequencer_cached (ROM_LAT=1 main DUT, ROM_LAT=3 second DUT).
module tb_program_sequencer_cached;
    localparam int ADDR_W = 8;
    localparam int LINES  = 4;
    localparam int WORDS  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, reset3_n;
    logic       sync_reset, jmp, jmp_nz, dont_jmp, flush;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc, pm_addr3, pc3;
    logic       hold_out, hold_out3;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count, miss_count, stall_count;
    logic [15:0] hit_count3, miss_count3, stall_count3;
`endif

    program_sequencer_cached_if #(.ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS)) mem0 ();
    program_sequencer_cached_if #(.ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS)) mem3 ();

    program_sequencer_cached #(.ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS), .ROM_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz),
        .dont_jmp(dont_jmp), .jmp_addr(jmp_addr), .flush(flush), .pm_addr(pm_addr), .pc(pc),
        .hold_out(hold_out),
`ifdef ICACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count), .stall_count(stall_count),
`endif
        .mem(mem0)
    );

    program_sequencer_cached #(.ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS), .ROM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset3_n), .sync_reset(1'b0), .jmp(1'b0), .jmp_nz(1'b0),
        .dont_jmp(1'b0), .jmp_addr(4'h0), .flush(1'b0), .pm_addr(pm_addr3), .pc(pc3),
        .hold_out(hold_out3),
`ifdef ICACHE_STATS_EN
        .hit_count(hit_count3), .miss_count(miss_count3), .stall_count(stall_count3),
`endif
        .mem(mem3)
    );

    typedef struct {
        logic       sr, jmp, jnz, dj;
        logic [3:0] ja;
        logic       fl;
        logic [7:0] pm;
        logic       hold;
        logic [7:0] pc;
        logic [7:0] rom;
        logic       wren;
        logic [2:0] off;
        logic [1:0] line;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_hits = 0;
    int   exp_stall = 0;
    logic prev_sr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic sr, input logic jm, input logic jnz, input logic dj,
                                 input logic [3:0] ja, input logic fl, input logic [7:0] pmv,
                                 input logic hold, input logic [7:0] pcv, input logic [7:0] rom,
                                 input logic wren, input logic [2:0] off, input logic [1:0] line);
        vec_t v;
        v.sr = sr; v.jmp = jm; v.jnz = jnz; v.dj = dj; v.ja = ja; v.fl = fl;
        v.pm = pmv; v.hold = hold; v.pc = pcv; v.rom = rom; v.wren = wren; v.off = off; v.line = line;
        tbl.push_back(v);
    endfunction

    function automatic void push_run(input logic sr, input logic jm, input logic jnz, input logic dj,
                                     input logic [3:0] ja, input logic fl, input logic [7:0] pmv,
                                     input logic hold, input logic [7:0] pcv);
        push(sr, jm, jnz, dj, ja, fl, pmv, hold, pcv, 8'h00, 1'b0, 3'd0, 2'd0);
    endfunction

    // Sequential hits: pm = start+i, pc lags by one.
    function automatic void push_hits(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++)
            push_run(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, start + 8'(i), 1'b0, start + 8'(i) - 8'd1);
    endfunction

    // One complete fill: issues base..base+7, writes lag by lat; noise drives an ignored jump.
    function automatic void push_fill(input logic [7:0] base, input logic [1:0] line, input logic [7:0] pcv,
                                      input int lat, input logic noise, input logic sr);
        for (int k = 0; k < WORDS + lat; k++)
            push(sr, noise, 1'b0, 1'b0, noise ? 4'h5 : 4'h0, 1'b0, sr ? 8'h00 : pcv, 1'b1, pcv,
                 (k < WORDS) ? base + 8'(k) : 8'h00, k >= lat, 3'(k - lat), line);
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        sync_reset = v.sr; jmp = v.jmp; jmp_nz = v.jnz; dont_jmp = v.dj; jmp_addr = v.ja; flush = v.fl;
        #2;
        check($sformatf("v%0d pm_addr", idx), 32'(pm_addr), 32'(v.pm));
        check($sformatf("v%0d hold_out", idx), 32'(hold_out), 32'(v.hold));
        check($sformatf("v%0d pc", idx), 32'(pc), 32'(v.pc));
        check($sformatf("v%0d rom_address", idx), 32'(mem0.rom_address), 32'(v.rom));
        check($sformatf("v%0d cache_wren", idx), 32'(mem0.cache_wren), 32'(v.wren));
        if (v.wren) begin
            check($sformatf("v%0d cache_wroffset", idx), 32'(mem0.cache_wroffset), 32'(v.off));
            check($sformatf("v%0d cache_wrline", idx), 32'(mem0.cache_wrline), 32'(v.line));
        end
        check($sformatf("v%0d cache_rd", idx), {27'd0, mem0.cache_rdline, mem0.cache_rdoffset}, 32'(v.pm[4:0]));
        if (v.fl || (v.sr && !prev_sr)) begin
            exp_hits = 0;
            exp_stall = 0;
        end else begin
            if (!v.hold && !v.sr) exp_hits++;
            if (v.hold) exp_stall++;
        end
        prev_sr = v.sr;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply_vec(tbl[i], n_tests);
        tbl.delete();
    endtask

    task automatic check_stats(input string name, input int hits, input int misses, input int stalls);
`ifdef ICACHE_STATS_EN
        check({name, " hit_count"}, 32'(hit_count), 32'(hits));
        check({name, " miss_count"}, 32'(miss_count), 32'(misses));
        check({name, " stall_count"}, 32'(stall_count), 32'(stalls));
`endif
    endtask

    initial begin
        int holds3;
        reset_n = 1'b0; reset3_n = 1'b0;
        sync_reset = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0; jmp_addr = 4'h0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset pc", 32'(pc), 32'h0);
        check("reset rom_address", 32'(mem0.rom_address), 32'h0);
        check("reset cache_wren", 32'(mem0.cache_wren), 32'h0);
        check("reset hold_out", 32'(hold_out), 32'h1);

        // ROM_LAT=3: miss at 0x01, 11 FILL cycles, writes lag issues by 3.
        reset3_n = 1'b1;
        holds3 = 0;
        for (int c = 0; c < 14; c++) begin
            #2;
            holds3 += int'(hold_out3);
            if (c == 0) begin
                check("lat3 miss pm", 32'(pm_addr3), 32'h01);
                check("lat3 miss hold", 32'(hold_out3), 32'h1);
            end else if (c <= 11) begin
                check($sformatf("lat3 k%0d pm", c - 1), 32'(pm_addr3), 32'h01);
                check($sformatf("lat3 k%0d rom", c - 1), 32'(mem3.rom_address), (c - 1 < 8) ? 32'(c - 1) : 32'h0);
                check($sformatf("lat3 k%0d wren", c - 1), 32'(mem3.cache_wren), 32'(c - 1 >= 3));
                if (c - 1 >= 3)
                    check($sformatf("lat3 k%0d off", c - 1), 32'(mem3.cache_wroffset), 32'(c - 4));
            end else begin
                check($sformatf("lat3 run%0d pm", c), 32'(pm_addr3), 32'(c - 10));
                check($sformatf("lat3 run%0d hold", c), 32'(hold_out3), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        check("lat3 hold cycles", 32'(holds3), 32'd12);

        // Cold start and sequential run through lines 0 and 1, then jump back.
        reset_n = 1'b1;
        push_run(1, 0, 0, 0, 4'h0, 0, 8'h00, 1, 8'h00);
        push_run(0, 0, 0, 0, 4'h0, 0, 8'h01, 1, 8'h00);
        push_fill(8'h00, 2'd0, 8'h01, 1, 1'b0, 1'b0);
        push_hits(8'h02, 6);
        push_run(0, 0, 0, 0, 4'h0, 0, 8'h08, 1, 8'h07);
        push_fill(8'h08, 2'd1, 8'h08, 1, 1'b0, 1'b0);
        push_hits(8'h09, 7);
        push_run(0, 1, 0, 0, 4'h0, 0, 8'h00, 0, 8'h0F);
        run_table();
        check_stats("scn2", exp_hits, 2, 20);
        check("scn2 stall model", 32'(exp_stall), 32'd20);

        // Conflict on line 0, branch qualifiers, line 2/3 fills and wrap at 0xFF.
        push_run(0, 1, 0, 0, 4'h2, 0, 8'h20, 1, 8'h00);
        push_fill(8'h20, 2'd0, 8'h20, 1, 1'b0, 1'b0);
        push_hits(8'h21, 1);
        push_run(0, 1, 0, 0, 4'h0, 0, 8'h00, 1, 8'h21);
        push_fill(8'h00, 2'd0, 8'h00, 1, 1'b0, 1'b0);
        push_hits(8'h01, 1);
        push_run(0, 0, 1, 1, 4'h5, 0, 8'h02, 0, 8'h01);
        push_run(0, 0, 1, 0, 4'h0, 0, 8'h00, 0, 8'h02);
        push_run(0, 1, 0, 0, 4'hF, 0, 8'hF0, 1, 8'h00);
        push_fill(8'hF0, 2'd2, 8'hF0, 1, 1'b0, 1'b0);
        push_hits(8'hF1, 7);
        push_run(0, 0, 0, 0, 4'h0, 0, 8'hF8, 1, 8'hF7);
        push_fill(8'hF8, 2'd3, 8'hF8, 1, 1'b1, 1'b0);
        push_hits(8'hF9, 7);
        push_run(0, 0, 0, 0, 4'h0, 0, 8'h00, 0, 8'hFF);

        // Flush in the 4th FILL cycle of a line-2 fill.
        push_run(0, 1, 0, 0, 4'h3, 0, 8'h30, 1, 8'h00);
        push(0, 0, 0, 0, 4'h0, 0, 8'h30, 1, 8'h30, 8'h30, 1'b0, 3'd0, 2'd2);
        push(0, 0, 0, 0, 4'h0, 0, 8'h30, 1, 8'h30, 8'h31, 1'b1, 3'd0, 2'd2);
        push(0, 0, 0, 0, 4'h0, 0, 8'h30, 1, 8'h30, 8'h32, 1'b1, 3'd1, 2'd2);
        push(0, 0, 0, 0, 4'h0, 1, 8'h30, 1, 8'h30, 8'h33, 1'b0, 3'd0, 2'd2);
        run_table();
        check_stats("flush", 0, 0, 0);
        push_run(0, 0, 0, 0, 4'h0, 0, 8'h31, 1, 8'h30);
        push_fill(8'h30, 2'd2, 8'h31, 1, 1'b0, 1'b0);
        push_hits(8'h32, 1);
        push_run(0, 1, 0, 0, 4'h0, 0, 8'h00, 1, 8'h32);
        push_fill(8'h00, 2'd0, 8'h00, 1, 1'b0, 1'b0);
        push_hits(8'h01, 1);
        run_table();
        check_stats("post flush", exp_hits, 2, exp_stall);

        // sync_reset held: one invalidate, refill of line 0 at pm_addr 0, then release.
        push_run(1, 0, 0, 0, 4'h0, 0, 8'h00, 0, 8'h01);
        push_run(1, 0, 0, 0, 4'h0, 0, 8'h00, 1, 8'h00);
        push_fill(8'h00, 2'd0, 8'h00, 1, 1'b0, 1'b1);
        push_run(1, 0, 0, 0, 4'h0, 0, 8'h00, 0, 8'h00);
        push_run(0, 0, 0, 0, 4'h0, 0, 8'h01, 0, 8'h00);
        run_table();
        check_stats("sync hold", exp_hits, 0, exp_stall);

        // Asynchronous reset mid-cycle clears pc and the valid bits.
        reset_n = 1'b0;
        #1;
        check("async rst pc", 32'(pc), 32'h0);
        check("async rst hold", 32'(hold_out), 32'h1);
        check_stats("async rst", 0, 0, 0);
        reset_n = 1'b1;
        #1;
        check("post rst pm", 32'(pm_addr), 32'h01);
        check("post rst miss", 32'(hold_out), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
